// File: rtl/wb_fifo_bridge_pkg.sv
// Shared types and elaboration helpers for the Wishbone store-and-forward FIFO bridge.
package wb_fifo_bridge_pkg;

  typedef enum logic {StIdle, StBusy} state_t;

  // Level counter needs one extra bit so that a completely full FIFO is representable.
  function automatic int unsigned level_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit params_legal(input int unsigned data_width,
                                      input int unsigned addr_width,
                                      input int unsigned af_level,
                                      input int unsigned ae_level,
                                      input int unsigned hold_cyc);
    int unsigned depth;
    depth = 1 << addr_width;
    return (data_width > 0) && (addr_width > 0) && (addr_width < 16) &&
           (af_level >= 1) && (af_level <= depth) && (ae_level < depth) && (hold_cyc <= 1);
  endfunction

endpackage

// File: rtl/fifo_addr_gen.sv
// Wrapping FIFO pointer: increments modulo 2**AddrWidth, synchronous clear.
module fifo_addr_gen #(
  parameter int unsigned AddrWidth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [AddrWidth-1:0] addr_o
);

  logic [AddrWidth-1:0] addr_d, addr_q;

  always_comb begin
    addr_d = addr_q;
    if (clr_i) begin
      addr_d = '0;
    end else if (inc_i) begin
      addr_d = addr_q + AddrWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/wb_fifo_bridge.sv
// Wishbone-classic store-and-forward FIFO: device-port pushes, controller-port single writes.
// Optional synchronous flush port is enabled by defining WB_FIFO_BRIDGE_FLUSH_EN.
module wb_fifo_bridge
  import wb_fifo_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = 12,
  parameter int unsigned AE_LEVEL   = 2,
  parameter int unsigned HOLD_CYC   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
`ifdef WB_FIFO_BRIDGE_FLUSH_EN
  input  logic                  flush_i,
`endif
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  output logic                  wbs_ack_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [DATA_WIDTH-1:0] wbm_dat_o,
  input  logic                  wbm_ack_i,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);

  localparam int unsigned Depth      = 1 << ADDR_WIDTH;
  localparam int unsigned LevelWidth = level_width(ADDR_WIDTH);

  typedef logic [LevelWidth-1:0] level_t;

  localparam level_t DepthLvl = level_t'(Depth);
  localparam level_t AfLvl    = level_t'(AF_LEVEL);
  localparam level_t AeLvl    = level_t'(AE_LEVEL);

  if (!params_legal(DATA_WIDTH, ADDR_WIDTH, AF_LEVEL, AE_LEVEL, HOLD_CYC)) begin : gen_param_check
    $error("wb_fifo_bridge: illegal parameter combination");
  end

  logic flush;
`ifdef WB_FIFO_BRIDGE_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  level_t                level_d, level_q;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic                  full, empty;
  logic                  push, pop;

  logic                  sack_d, sack_q;
  logic [DATA_WIDTH-1:0] sdat_d, sdat_q;

  state_t                state_d, state_q;
  logic                  stb_d, stb_q;
  logic                  drop_d, drop_q;
  logic [DATA_WIDTH-1:0] mdat_d, mdat_q;

  assign full  = (level_q == DepthLvl);
  assign empty = (level_q == '0);

  fifo_addr_gen #(
    .AddrWidth (ADDR_WIDTH)
  ) u_wr_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush),
    .inc_i  (push),
    .addr_o (wr_addr)
  );

  fifo_addr_gen #(
    .AddrWidth (ADDR_WIDTH)
  ) u_rd_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush),
    .inc_i  (pop),
    .addr_o (rd_addr)
  );

  // Device port: ack is a single registered pulse; full is taken from the registered level.
  always_comb begin
    sack_d = wbs_cyc_i & wbs_stb_i & ~sack_q & (~wbs_we_i | ~full) & ~flush;
    push   = sack_d & wbs_we_i;
    sdat_d = sdat_q;
    if (sack_d && !wbs_we_i) begin
      sdat_d = DATA_WIDTH'(level_q);
    end
  end

  always_comb begin
    if (flush) begin
      level_d = '0;
    end else begin
      level_d = level_q + level_t'(push) - level_t'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_addr] <= wbs_dat_i;
    end
  end

  // Controller FSM. A word whose FIFO entry was flushed still completes on the bus,
  // but drop_q keeps its ack from popping the (already cleared) FIFO.
  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    drop_d  = drop_q;
    mdat_d  = mdat_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !flush) begin
          state_d = StBusy;
          stb_d   = 1'b1;
          mdat_d  = mem_q[rd_addr];
        end
      end
      StBusy: begin
        if (stb_q && wbm_ack_i) begin
          pop    = ~drop_q & ~flush;
          stb_d  = 1'b0;
          drop_d = 1'b0;
          if (!((HOLD_CYC != 0) && pop && (level_q > level_t'(1)))) begin
            state_d = StIdle;
          end
        end else if (!stb_q) begin
          // Hold-mode gap cycle between back-to-back words.
          if (flush) begin
            state_d = StIdle;
          end else begin
            stb_d  = 1'b1;
            mdat_d = mem_q[rd_addr];
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= '0;
      sack_q  <= 1'b0;
      sdat_q  <= '0;
      state_q <= StIdle;
      stb_q   <= 1'b0;
      drop_q  <= 1'b0;
      mdat_q  <= '0;
    end else begin
      level_q <= level_d;
      sack_q  <= sack_d;
      sdat_q  <= sdat_d;
      state_q <= state_d;
      stb_q   <= stb_d;
      drop_q  <= drop_d;
      mdat_q  <= mdat_d;
    end
  end

  assign wbs_ack_o      = sack_q;
  assign wbs_dat_o      = sdat_q;
  assign wbm_cyc_o      = (state_q == StBusy);
  assign wbm_stb_o      = stb_q;
  assign wbm_we_o       = (state_q == StBusy);
  assign wbm_dat_o      = mdat_q;
  assign level_o        = level_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (level_q >= AfLvl);
  assign almost_empty_o = (level_q <= AeLvl);

endmodule

// File: tb/tb_wb_fifo_bridge.sv
// Self-checking bench for wb_fifo_bridge (DEPTH=4), plus a HOLD_CYC=1 instance.
module tb_wb_fifo_bridge;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [DW-1:0] dat_i = '0;
  logic          ack_i = 1'b0, h_ack_i = 1'b0;
  logic          flush = 1'b0;

  logic [DW-1:0] s_dat, m_dat, h_sdat, h_dat;
  logic          s_ack, m_cyc, m_stb, m_we, full, empty, af, ae;
  logic          h_sack, h_cyc, h_stb, h_we, h_full, h_empty, h_af, h_ae;
  logic [AW:0]   level, h_level;

  wb_fifo_bridge #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .AF_LEVEL (3), .AE_LEVEL (1), .HOLD_CYC (0)
  ) dut (
    .clk_i (clk), .rst_ni (rst_n),
`ifdef WB_FIFO_BRIDGE_FLUSH_EN
    .flush_i (flush),
`endif
    .wbs_cyc_i (cyc_i), .wbs_stb_i (stb_i), .wbs_we_i (we_i), .wbs_dat_i (dat_i),
    .wbs_dat_o (s_dat), .wbs_ack_o (s_ack),
    .wbm_cyc_o (m_cyc), .wbm_stb_o (m_stb), .wbm_we_o (m_we), .wbm_dat_o (m_dat),
    .wbm_ack_i (ack_i), .level_o (level), .full_o (full), .empty_o (empty),
    .almost_full_o (af), .almost_empty_o (ae)
  );

  wb_fifo_bridge #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .AF_LEVEL (3), .AE_LEVEL (1), .HOLD_CYC (1)
  ) dut_h (
    .clk_i (clk), .rst_ni (rst_n),
`ifdef WB_FIFO_BRIDGE_FLUSH_EN
    .flush_i (flush),
`endif
    .wbs_cyc_i (cyc_i), .wbs_stb_i (stb_i), .wbs_we_i (we_i), .wbs_dat_i (dat_i),
    .wbs_dat_o (h_sdat), .wbs_ack_o (h_sack),
    .wbm_cyc_o (h_cyc), .wbm_stb_o (h_stb), .wbm_we_o (h_we), .wbm_dat_o (h_dat),
    .wbm_ack_i (h_ack_i), .level_o (h_level), .full_o (h_full), .empty_o (h_empty),
    .almost_full_o (h_af), .almost_empty_o (h_ae)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb_q[$];
  bit auto_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Downstream responder: acks every strobe and checks the word against the scoreboard.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (auto_ack) begin
        ack_i = 1'b0;
        if (m_cyc && m_stb) begin
          if (sb_q.size() == 0) chk("sb_unexpected_word", sb_q.size(), 1);
          else chk("sb_order", m_dat, sb_q.pop_front());
          ack_i = 1'b1;
        end
      end
    end
  end

  task automatic wb_push(input logic [DW-1:0] d, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = d;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      waited++;
      if (s_ack) begin
        got = 1'b1;
        break;
      end
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    chk("push_acked", got, 1);
    if (got) sb_q.push_back(d);
  endtask

  task automatic wb_read(output logic [DW-1:0] d);
    bit got;
    got = 1'b0;
    d = '0;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (s_ack) begin
        got = 1'b1;
        d = s_dat;
        break;
      end
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    chk("read_acked", got, 1);
  endtask

  task automatic drain();
    auto_ack = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (empty && !m_cyc) break;
    end
    auto_ack = 1'b0;
    ack_i = 1'b0;
    chk("drain_empty", empty, 1);
    chk("drain_sb_size", sb_q.size(), 0);
  endtask

  typedef struct {
    bit          we;
    logic [7:0]  dat;
    logic [7:0]  exp_rd;
    logic [2:0]  exp_lvl;
    bit          exp_full;
    bit          exp_empty;
    bit          exp_af;
    bit          exp_ae;
  } vec_t;

  vec_t vecs[6];
  logic [DW-1:0] hexp[3];

  initial begin
    int w;
    logic [DW-1:0] rd;
    int pulses, gaps;
    bit seen;

    vecs[0] = '{1'b1, 8'h11, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 8'h22, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h33, 8'h00, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 8'h03, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h44, 8'h00, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 8'h04, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0};
    hexp[0] = 8'h71; hexp[1] = 8'h72; hexp[2] = 8'h73;

    // Reset state
    #2;
    chk("rst_wbs_ack", s_ack, 0);
    chk("rst_wbs_dat", s_dat, 0);
    chk("rst_cyc", m_cyc, 0);
    chk("rst_stb", m_stb, 0);
    chk("rst_we", m_we, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", ae, 1);
    chk("rst_af", af, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word: ack one cycle after request, cyc one cycle after ack
    auto_ack = 1'b1;
    wb_push(8'hA5, w);
    chk("t1_ack_latency", w, 1);
    chk("t1_cyc_before", m_cyc, 0);
    @(posedge clk); #1;
    chk("t1_cyc", m_cyc, 1);
    chk("t1_we", m_we, 1);
    chk("t1_dat", m_dat, 8'hA5);
    @(posedge clk); #1;
    chk("t1_empty_after", empty, 1);
    chk("t1_cyc_after", m_cyc, 0);
    auto_ack = 1'b0;
    ack_i = 1'b0;
    chk("t1_sb_size", sb_q.size(), 0);

    // Table: fill to DEPTH with level reads; consumer never acks
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (vecs[i].we) begin
        wb_push(vecs[i].dat, w);
      end else begin
        wb_read(rd);
        chk("vec_read_level", rd, vecs[i].exp_rd);
      end
      chk("vec_level", level, vecs[i].exp_lvl);
      chk("vec_full", full, vecs[i].exp_full);
      chk("vec_empty", empty, vecs[i].exp_empty);
      chk("vec_af", af, vecs[i].exp_af);
      chk("vec_ae", ae, vecs[i].exp_ae);
    end

    // Fifth push stalls while full, released one cycle after a single downstream pop
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t2_stall_no_ack", s_ack, 0);
    end
    chk("t2_stb_pending", m_stb, 1);
    chk("t2_head_word", m_dat, sb_q.pop_front());
    ack_i = 1'b1;
    @(posedge clk); #1;
    ack_i = 1'b0;
    chk("t2_no_bypass", s_ack, 0);
    chk("t2_level_after_pop", level, 3);
    @(posedge clk); #1;
    chk("t2_release_ack", s_ack, 1);
    chk("t2_level_refill", level, 4);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    sb_q.push_back(8'h55);
    drain();

    // Push and pop on the same edge at level 2
    wb_push(8'h01, w);
    wb_push(8'h02, w);
    @(posedge clk); #1;
    chk("t3_level2", level, 2);
    chk("t3_stb", m_stb, 1);
    chk("t3_head", m_dat, sb_q.pop_front());
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 8'h03; ack_i = 1'b1;
    @(posedge clk); #1;
    chk("t3_push_ack", s_ack, 1);
    chk("t3_level_same", level, 2);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; ack_i = 1'b0;
    sb_q.push_back(8'h03);
    drain();

    // Asynchronous reset in the middle of a downstream cycle
    wb_push(8'h66, w);
    @(posedge clk); #1;
    chk("t6_busy", m_cyc, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_cyc", m_cyc, 0);
    chk("t6_rst_stb", m_stb, 0);
    chk("t6_rst_we", m_we, 0);
    chk("t6_rst_dat", m_dat, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_empty", empty, 1);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Hold mode: cyc stays high across three queued words
    wb_push(8'h71, w);
    wb_push(8'h72, w);
    wb_push(8'h73, w);
    pulses = 0; gaps = 0; seen = 1'b0;
    for (int i = 0; i < 40 && pulses < 3; i++) begin
      @(posedge clk); #1;
      h_ack_i = 1'b0;
      if (h_cyc) seen = 1'b1;
      else if (seen) gaps++;
      if (h_stb) begin
        chk("t5_hold_word", h_dat, hexp[pulses]);
        pulses++;
        h_ack_i = 1'b1;
      end
    end
    @(posedge clk); #1;
    h_ack_i = 1'b0;
    chk("t5_pulses", pulses, 3);
    chk("t5_cyc_gaps", gaps, 0);
    chk("t5_cyc_end", h_cyc, 0);
    chk("t5_we_end", h_we, 0);
    chk("t5_empty", h_empty, 1);
    drain();

`ifdef WB_FIFO_BRIDGE_FLUSH_EN
    // Flush at level 3; in-flight word completes without decrementing level
    wb_push(8'h81, w);
    wb_push(8'h82, w);
    wb_push(8'h83, w);
    chk("fl_level3", level, 3);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_level0", level, 0);
    chk("fl_empty", empty, 1);
    chk("fl_inflight_stb", m_stb, 1);
    ack_i = 1'b1;
    @(posedge clk); #1;
    ack_i = 1'b0;
    chk("fl_level_kept", level, 0);
    chk("fl_cyc_drop", m_cyc, 0);
    sb_q.delete();
    wb_push(8'h99, w);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
